// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the CPU memory subsystem.
// Holds address/data widths, memory depth, arbiter states and port identifiers.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MEM_DEPTH = 4096;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_CPU  = 1'b1
    } port_id_t;

endpackage

// File: rtl/mem_clear_seq.sv
// Address sweep counter for the memory clear sequence.
// Counts 0..DEPTH-1 while run is high and flags the final address.
module mem_clear_seq #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DEPTH  = cpu_pkg::MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Held at zero outside a sweep so every sweep starts from address 0.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            addr <= '0;
        end else begin
            addr <= addr + 1'b1;
        end
    end

    assign done = (addr == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data memory between the host loader and the CPU,
// with a host-priority arbiter, a CPU starvation guard and a whole-memory clear sweep.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W         = cpu_pkg::DATA_W,
    parameter int unsigned DEPTH          = cpu_pkg::MEM_DEPTH,
    parameter int unsigned HOST_BURST_MAX = 4
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              clr_mem,
    output logic              clr_busy,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import cpu_pkg::*;

    localparam int unsigned     SW         = $clog2(HOST_BURST_MAX + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(HOST_BURST_MAX);

    arb_state_t        state, state_next;
    logic [SW-1:0]     streak;
    logic              rd_pending;
    port_id_t          rd_owner;
    logic              seq_run;
    logic              seq_done;
    logic [ADDR_W-1:0] seq_addr;

    mem_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk   (main_clk),
        .reset (reset),
        .run   (seq_run),
        .addr  (seq_addr),
        .done  (seq_done)
    );

    always_ff @(posedge main_clk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        host_gnt   = 1'b0;
        cpu_gnt    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        seq_run    = 1'b0;
        if (!reset) begin
            unique case (state)
                ARB: begin
                    if (clr_mem) begin
                        state_next = CLEAR;
                    end else if (host_req && !(cpu_req && (streak == STREAK_MAX))) begin
                        host_gnt  = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = host_we;
                        mem_addr  = host_addr;
                        mem_wdata = host_wdata;
                    end else if (cpu_req) begin
                        cpu_gnt   = 1'b1;
                        mem_en    = 1'b1;
                        mem_we    = cpu_we;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                end
                CLEAR: begin
                    seq_run  = 1'b1;
                    mem_en   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = seq_addr;
                    if (seq_done) begin
                        state_next = ARB;
                    end
                end
                default: ;
            endcase
        end
    end

    // Streak only advances on host wins the CPU actually contested.
    always_ff @(posedge main_clk) begin
        if (reset || cpu_gnt || !cpu_req) begin
            streak <= '0;
        end else if (host_gnt) begin
            streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= PORT_HOST;
        end else begin
            rd_pending <= (host_gnt && !host_we) || (cpu_gnt && !cpu_we);
            rd_owner   <= cpu_gnt ? PORT_CPU : PORT_HOST;
        end
    end

    assign clr_busy    = (state == CLEAR);
    assign host_rvalid = rd_pending && (rd_owner == PORT_HOST);
    assign cpu_rvalid  = rd_pending && (rd_owner == PORT_CPU);
    assign host_rdata  = mem_rdata;
    assign cpu_rdata   = mem_rdata;

endmodule
